// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the program-counter run controller.
//   run_state_t   : controller state, 2-bit encoding visible on the state port
//   SLOW_DIV_DEF  : default clk cycles per advance in normal run
//   FAST_DIV_DEF  : default clk cycles per advance in speedrun
//   DIV_W         : width of the tick divider (covers divisors up to 2^26-1)
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } run_state_t;

  localparam int unsigned SLOW_DIV_DEF = 25000000;
  localparam int unsigned FAST_DIV_DEF = 250000;
  localparam int          DIV_W        = 26;

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer and rising-edge detector.
//   clk, rst_n : system clock, async active-low reset
//   btn        : asynchronous button level (debounced upstream)
//   evt        : registered one-cycle event per rising edge of btn
// A button rising at edge N gives evt high in the cycle after edge N+2,
// so the consumer acts on it at edge N+3. A held level gives one event.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      evt    <= sync_2 & ~sync_3;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Execution-rate divider.
//   clk, rst_n : system clock, async active-low reset
//   en         : count enable (high only while running)
//   clr        : restart the period from zero
//   div        : clk cycles per tick (>= 2)
//   tick       : high for the last cycle of each period
// The count is held at zero whenever en is low, so every entry into
// running starts a full period.
module tick_gen
  import run_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == (div - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequencing controller for the model computer's program counter.
//   clk, rst_n    : system clock, async active-low reset
//   run_btn       : run request (async level)
//   speedrun_btn  : fast-run request (async level)
//   step_btn      : single-step request (async level)
//   stop_btn      : stop / clear-halt request (async level)
//   halt_req      : decoded HLT from datapath (sync level)
//   jump_req      : taken branch from datapath (sync level)
//   pc_step       : one-cycle pulse, PC += STEP
//   pc_load       : one-cycle pulse, PC <= jump value
//   running       : high only in RUN
//   speed         : 0 = slow rate, 1 = fast rate
//   state         : IDLE=0, RUN=1, STEP=2, HALT=3
//   adv_count     : advances issued since reset (wraps)
// pc_step and pc_load are registered; each advance raises exactly one of
// them for one cycle, the cycle after the tick (or STEP cycle) that caused it.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned SLOW_DIV = SLOW_DIV_DEF,
  parameter int unsigned FAST_DIV = FAST_DIV_DEF,
  parameter int          CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_btn,
  input  logic             speedrun_btn,
  input  logic             step_btn,
  input  logic             stop_btn,
  input  logic             halt_req,
  input  logic             jump_req,
  output logic             pc_step,
  output logic             pc_load,
  output logic             running,
  output logic             speed,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] adv_count
);

  run_state_t       state_q;
  logic             run_ev;
  logic             sr_ev;
  logic             step_ev;
  logic             stop_ev;
  logic             tick;
  logic             div_clr;
  logic [DIV_W-1:0] div;

  btn_edge u_run_edge  (.clk(clk), .rst_n(rst_n), .btn(run_btn),      .evt(run_ev));
  btn_edge u_sr_edge   (.clk(clk), .rst_n(rst_n), .btn(speedrun_btn), .evt(sr_ev));
  btn_edge u_step_edge (.clk(clk), .rst_n(rst_n), .btn(step_btn),     .evt(step_ev));
  btn_edge u_stop_edge (.clk(clk), .rst_n(rst_n), .btn(stop_btn),     .evt(stop_ev));

  assign div = speed ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);

  // Any rate/stop command restarts the period; outside RUN the divider is
  // held at zero by en.
  assign div_clr = stop_ev | run_ev | sr_ev;

  tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .clr   (div_clr),
    .div   (div),
    .tick  (tick)
  );

  assign state = state_q;

  // Command priority: stop > speedrun > run > step. In RUN a run/speedrun
  // command restarts the period, so a tick in that same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running   <= 1'b0;
      speed     <= 1'b0;
      pc_step   <= 1'b0;
      pc_load   <= 1'b0;
      adv_count <= '0;
    end else begin
      pc_step <= 1'b0;
      pc_load <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (stop_ev) begin
            state_q <= ST_IDLE;
          end else if (sr_ev) begin
            state_q <= ST_RUN;
            running <= 1'b1;
            speed   <= 1'b1;
          end else if (run_ev) begin
            state_q <= ST_RUN;
            running <= 1'b1;
            speed   <= 1'b0;
          end else if (step_ev) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (stop_ev) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
          end else if (sr_ev || run_ev) begin
            speed <= sr_ev;
          end else if (tick) begin
            if (halt_req) begin
              state_q <= ST_HALT;
              running <= 1'b0;
            end else begin
              pc_load   <= jump_req;
              pc_step   <= ~jump_req;
              adv_count <= adv_count + CNT_W'(1);
            end
          end
        end
        ST_STEP: begin
          if (stop_ev) begin
            state_q <= ST_IDLE;
          end else if (halt_req) begin
            state_q <= ST_HALT;
          end else begin
            state_q   <= ST_IDLE;
            pc_load   <= jump_req;
            pc_step   <= ~jump_req;
            adv_count <= adv_count + CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (stop_ev) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
